// File: rtl/aes_dec_round_sched_if.sv
// Start/done handshake bundle between the AES decrypt round sequencer and its
// ARK / ISB / IMC sub-blocks, plus the shared statemt port owner select.
interface aes_dec_round_sched_if #(
    parameter int N_W = 5
);
    logic           ark_start;
    logic           ark_done;
    logic [N_W-1:0] ark_n;
    logic           isb_start;
    logic           isb_done;
    logic           imc_start;
    logic           imc_done;
    logic [2:0]     port_sel;

    modport master (
        output ark_start, ark_n, isb_start, imc_start, port_sel,
        input  ark_done, isb_done, imc_done
    );

    modport slave (
        input  ark_start, ark_n, isb_start, imc_start, port_sel,
        output ark_done, isb_done, imc_done
    );
endinterface

// File: rtl/aes_dec_round_sched.sv
// AES decrypt round sequencer: walks ARK/ISB/IMC in decrypt order, drives the
// ARK round index and statemt ownership, and aborts on a stalled sub-block.
//
// state | meaning
// IDLE  | waiting for ap_start
// ARK0  | initial AddRoundKey with round key nr
// ISB   | InvShiftRows+InvSubBytes of a middle round
// ARKR  | AddRoundKey of a middle round
// IMC   | InvMixColumns of a middle round
// ISBL  | InvShiftRows+InvSubBytes of the last round
// ARKL  | final AddRoundKey with round key 0
// FIN   | one-cycle ap_done, back to IDLE
module aes_dec_round_sched #(
    parameter int NR_W    = 4,
    parameter int N_W     = 5,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    input  logic [NR_W-1:0]      nr,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic                 ap_ready,
    output logic                 err,
    output logic [NR_W-1:0]      round,
    aes_dec_round_sched_if.master sub
);

    typedef enum logic [2:0] {
        IDLE, ARK0, ISB, ARKR, IMC, ISBL, ARKL, FIN
    } state_t;

    localparam bit               WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [NR_W-1:0]   round_q, round_d;
    logic [CNT_W-1:0]  wd_q, wd_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              idle_q, idle_d;
    logic              ark_start_q, ark_start_d;
    logic              isb_start_q, isb_start_d;
    logic              imc_start_q, imc_start_d;
    logic [N_W-1:0]    ark_n_q, ark_n_d;
    logic [2:0]        port_sel_q, port_sel_d;

    logic              wait_st;
    logic              owner_done;
    logic              timeout;

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        err_d      = err_q;
        wd_d       = wd_q;
        ready_d    = 1'b0;
        wait_st    = 1'b0;
        owner_done = 1'b0;

        case (state_q)
            ARK0, ARKR, ARKL: begin
                wait_st    = 1'b1;
                owner_done = sub.ark_done;
            end
            ISB, ISBL: begin
                wait_st    = 1'b1;
                owner_done = sub.isb_done;
            end
            IMC: begin
                wait_st    = 1'b1;
                owner_done = sub.imc_done;
            end
            default: begin
                wait_st    = 1'b0;
                owner_done = 1'b0;
            end
        endcase

        // a done in the timeout cycle still counts as success
        timeout = WD_EN && wait_st && !owner_done && (wd_q == WD_LAST);

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    round_d = nr;
                    ready_d = 1'b1;
                    err_d   = 1'b0;
                    state_d = (nr != '0) ? ARK0 : ARKL;
                end
            end
            ARK0: begin
                if (sub.ark_done) begin
                    round_d = round_q - 1'b1;
                    state_d = (round_q > NR_W'(1)) ? ISB : ISBL;
                end
            end
            ISB: begin
                if (sub.isb_done) state_d = ARKR;
            end
            ARKR: begin
                if (sub.ark_done) state_d = IMC;
            end
            IMC: begin
                if (sub.imc_done) begin
                    if (round_q == NR_W'(1)) begin
                        state_d = ISBL;
                    end else begin
                        round_d = round_q - 1'b1;
                        state_d = ISB;
                    end
                end
            end
            ISBL: begin
                if (sub.isb_done) state_d = ARKL;
            end
            ARKL: begin
                if (sub.ark_done) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout) begin
            state_d = FIN;
            err_d   = 1'b1;
        end

        if (state_d != state_q) begin
            wd_d = '0;
        end else if (WD_EN && wait_st) begin
            wd_d = wd_q + CNT_W'(1);
        end

        // outputs are a function of the next state so they register alongside it
        ark_start_d = (state_d == ARK0) || (state_d == ARKR) || (state_d == ARKL);
        isb_start_d = (state_d == ISB)  || (state_d == ISBL);
        imc_start_d = (state_d == IMC);
        ark_n_d     = ((state_d == ARK0) || (state_d == ARKR)) ? N_W'(round_d) : '0;
        port_sel_d  = {imc_start_d, isb_start_d, ark_start_d};
        idle_d      = (state_d == IDLE);
        done_d      = (state_d == FIN);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            round_q     <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            idle_q      <= 1'b1;
            ark_start_q <= 1'b0;
            isb_start_q <= 1'b0;
            imc_start_q <= 1'b0;
            ark_n_q     <= '0;
            port_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            idle_q      <= idle_d;
            ark_start_q <= ark_start_d;
            isb_start_q <= isb_start_d;
            imc_start_q <= imc_start_d;
            ark_n_q     <= ark_n_d;
            port_sel_q  <= port_sel_d;
        end
    end

    assign ap_done       = done_q;
    assign ap_idle       = idle_q;
    assign ap_ready      = ready_q;
    assign err           = err_q;
    assign round         = round_q;
    assign sub.ark_start = ark_start_q;
    assign sub.isb_start = isb_start_q;
    assign sub.imc_start = imc_start_q;
    assign sub.ark_n     = ark_n_q;
    assign sub.port_sel  = port_sel_q;

endmodule

// File: tb/tb_aes_dec_round_sched.sv
// Scoreboard bench for aes_dec_round_sched: a decrypt-order model queues the
// expected start/done events, a monitor pops and compares them as they appear.
module tb_aes_dec_round_sched;

    localparam int NR_W  = 4;
    localparam int N_W   = 5;
    localparam int TMO   = 16;
    localparam int CNT_W = 11;

    localparam int K_ARK  = 0;
    localparam int K_ISB  = 1;
    localparam int K_IMC  = 2;
    localparam int K_DONE = 3;

    logic            ap_clk   = 1'b0;
    logic            ap_rst_n = 1'b1;
    logic            ap_start = 1'b0;
    logic [NR_W-1:0] nr       = '0;
    logic            ap_done;
    logic            ap_idle;
    logic            ap_ready;
    logic            err;
    logic [NR_W-1:0] round;

    aes_dec_round_sched_if #(.N_W(N_W)) sub_if ();

    aes_dec_round_sched #(
        .NR_W(NR_W), .N_W(N_W), .TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .nr       (nr),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .err      (err),
        .round    (round),
        .sub      (sub_if)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [1:0] kind;
        logic [4:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  spur     = 1'b0;
    bit  no_imc   = 1'b0;
    int  cur_dly[3];
    int  cnt[3];
    int  hi_cnt[3];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_ev(input int k, input int v);
        ev_t e;
        e.kind = 2'(k);
        e.val  = 5'(v);
        exp_q.push_back(e);
    endtask

    // Decrypt order: ARK(nr), {ISB, ARK(r), IMC} for r=nr-1..1, ISB, ARK(0).
    // With a stalled IMC the run stops after the first IMC and finishes with err.
    task automatic push_model(input int n, input bit tmo);
        if (n == 0) begin
            push_ev(K_ARK, 0);
        end else begin
            push_ev(K_ARK, n);
            for (int r = n - 1; r >= 1; r--) begin
                push_ev(K_ISB, 0);
                push_ev(K_ARK, r);
                push_ev(K_IMC, 0);
                if (tmo) break;
            end
            if (!tmo) begin
                push_ev(K_ISB, 0);
                push_ev(K_ARK, 0);
            end
        end
        push_ev(K_DONE, int'(tmo));
    endtask

    // sub-block responder: done after a random number of cycles of start
    always @(negedge ap_clk) begin
        logic [2:0] st;
        logic [2:0] d;
        st = {sub_if.imc_start, sub_if.isb_start, sub_if.ark_start};
        d  = '0;
        for (int b = 0; b < 3; b++) begin
            if (st[b]) begin
                if (cnt[b] == 0)
                    cur_dly[b] = (b == 2 && no_imc) ? TMO : int'($urandom_range(1, 12));
                cnt[b]++;
                if (cnt[b] == cur_dly[b] && !(b == 2 && no_imc)) d[b] = 1'b1;
            end else begin
                cnt[b] = 0;
            end
        end
        if (spur && st[0]) d[2:1] = 2'b11;
        sub_if.ark_done = d[0];
        sub_if.isb_done = d[1];
        sub_if.imc_done = d[2];
    end

    // monitor
    logic [2:0] prev_st   = '0;
    logic       prev_done = 1'b0;
    always @(negedge ap_clk) begin
        logic [2:0] st;
        ev_t        e;
        st = {sub_if.imc_start, sub_if.isb_start, sub_if.ark_start};
        if (ap_rst_n) begin
            for (int b = 0; b < 3; b++) begin
                if (st[b] && !prev_st[b]) begin
                    hi_cnt[b] = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_start actual=block%0d required=none", b);
                    end else begin
                        e = exp_q.pop_front();
                        chk("start_kind", b, int'(e.kind));
                        if (b == 0) chk("ark_n", int'(sub_if.ark_n), int'(e.val));
                        chk("port_sel", int'(sub_if.port_sel), 1 << b);
                    end
                end else if (st[b]) begin
                    hi_cnt[b]++;
                end else if (prev_st[b]) begin
                    chk("start_len", hi_cnt[b], cur_dly[b]);
                end
            end
            if (ap_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", int'(e.kind), K_DONE);
                    chk("done_err", int'(err), int'(e.val));
                    chk("fin_quiet", int'({st, sub_if.port_sel, ap_idle}), 0);
                end
            end
            if (prev_done) chk("done_pulse", int'({ap_done, ap_idle}), 1);
        end
        prev_st   = st;
        prev_done = ap_done;
    end

    task automatic do_start(input int n, input bit tmo);
        int k;
        push_model(n, tmo);
        @(negedge ap_clk);
        nr       = NR_W'(n);
        ap_start = 1'b1;
        k = 0;
        do begin
            @(negedge ap_clk);
            k++;
        end while (!ap_ready && k < 20);
        chk("ap_ready", int'(ap_ready), 1);
        chk("err_clear", int'(err), 0);
        ap_start = 1'b0;
        nr       = NR_W'($urandom);
        @(negedge ap_clk);
        chk("ready_pulse", int'(ap_ready), 0);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!ap_done && k < 3000) begin
            @(negedge ap_clk);
            k++;
        end
        if (!ap_done) begin
            checks++;
            failures++;
            $display("FAIL done_wait actual=no_done required=ap_done");
            ap_rst_n = 1'b0;
            @(negedge ap_clk);
            ap_rst_n = 1'b1;
        end
        @(negedge ap_clk);
        chk("idle_after", int'(ap_idle), 1);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int k;
        #2 ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        #1;
        chk("rst_idle", int'(ap_idle), 1);
        chk("rst_done", int'(ap_done), 0);
        chk("rst_ready", int'(ap_ready), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_starts", int'({sub_if.imc_start, sub_if.isb_start, sub_if.ark_start}), 0);
        chk("rst_port_sel", int'(sub_if.port_sel), 0);
        chk("rst_ark_n", int'(sub_if.ark_n), 0);
        chk("rst_round", int'(round), 0);
        ap_rst_n = 1'b1;

        do_start(10, 1'b0); wait_done();
        do_start(1, 1'b0);  wait_done();
        do_start(0, 1'b0);  wait_done();

        spur = 1'b1;
        do_start(3, 1'b0); wait_done();
        spur = 1'b0;

        no_imc = 1'b1;
        do_start(10, 1'b1); wait_done();
        chk("err_sticky", int'(err), 1);
        no_imc = 1'b0;
        do_start(4, 1'b0); wait_done();

        for (int i = 0; i < 10; i++) begin
            do_start(int'($urandom_range(0, 14)), 1'b0);
            wait_done();
        end

        do_start(10, 1'b0);
        k = 0;
        while (!(sub_if.isb_start && round == NR_W'(5)) && k < 1000) begin
            @(negedge ap_clk);
            k++;
        end
        chk("reach_isb_r5", int'({sub_if.isb_start, round}), 16 + 5);
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_starts", int'({sub_if.imc_start, sub_if.isb_start, sub_if.ark_start}), 0);
        chk("mid_rst_port_sel", int'(sub_if.port_sel), 0);
        chk("mid_rst_idle", int'(ap_idle), 1);
        chk("mid_rst_done", int'(ap_done), 0);
        exp_q.delete();
        repeat (3) @(negedge ap_clk);
        chk("mid_rst_no_done", int'({ap_done, ap_idle}), 1);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        do_start(12, 1'b0); wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_dec_round_sched.md
Name: aes_dec_round_sched

Overview:
- Top-level round sequencer for the AES decrypt datapath.
- Starts the round sub-blocks in decrypt order over their ap-style start/done handshakes: AddRoundKey (ARK), combined InvShiftRows+InvSubBytes (ISB), and InvMixColumns (IMC).
- Drives the ARK round index `n`.
- Issues a one-hot statemt-port ownership select so one shared statemt RAM serves all three sub-blocks.
- A watchdog aborts the sequence if any sub-block stalls.

Parameters:
- NR_W, 4, width of round-count input.
- N_W, 5, width of ARK round index output (matches ARK `n` port).
- TIMEOUT, 1024, max cycles to wait for any single sub-block done; 0 disables the watchdog.
- CNT_W, 11, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  request a full decrypt; level, sampled in IDLE.
- nr  in  NR_W  number of rounds (10/12/14 nominal); latched on accept.
- ap_done  out  1  one-cycle pulse: sequence finished or aborted.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  one-cycle pulse on accept of ap_start.
- err  out  1  sticky timeout flag; cleared on next accept.
- ark_start  out  1  ARK start.
- ark_done  in  1  ARK done.
- ark_n  out  N_W  ARK round index.
- isb_start  out  1  ISB start.
- isb_done  in  1  ISB done.
- imc_start  out  1  IMC start.
- imc_done  in  1  IMC done.
- port_sel  out  3  one-hot statemt owner: bit0 ARK, bit1 ISB, bit2 IMC; 0 when no owner.
- round  out  NR_W  current round counter (debug/status).

Behaviour:
- Reset (async, ap_rst_n=0):
  - FSM=IDLE.
  - Round counter cleared; ark_n=0.
  - All *_start=0, port_sel=0.
  - ap_done=0, ap_ready=0, err=0; ap_idle=1.
  - Watchdog counter=0.
  - Reset mid-sequence aborts immediately; no done pulse is produced.
- States: IDLE, ARK0, ISB, ARKR, IMC, ISBL, ARKL, FIN.
- IDLE:
  - While ap_start=0, stay in IDLE.
  - On ap_start=1: latch nr into round; pulse ap_ready; clear err.
  - Then go to ARK0 if nr!=0, else ARKL.
- Wait-state rule (ARK0/ISB/ARKR/IMC/ISBL/ARKL):
  - The owning *_start is held high, and port_sel is one-hot for that owner, for the whole state.
  - Exit on the first cycle the owner's done=1. The registered FSM drops start on the next cycle.
  - Only the owner's done is examined; done from a non-owner is ignored.
- Sequencing and ark_n:
  - ARK0: ark_n=round (=nr); on ark_done, round<=round-1.
    - If the new round>=1, go to ISB; else go to ISBL. For nr=1, ARK0 goes straight to ISBL.
  - ISB -> ARKR on isb_done. ARKR uses ark_n=round.
  - ARKR -> IMC on ark_done.
  - IMC on imc_done: if round==1, go to ISBL; else round<=round-1 and go to ISB.
  - ISBL -> ARKL on isb_done.
  - ARKL: ark_n=0; on ark_done go to FIN.
  - FIN: ap_done=1 for exactly one cycle, then IDLE. ap_start is not re-sampled in FIN.
  - Full nr=10 sequence: ARK(10), then {ISB, ARK(r), IMC} for r=9..1, then ISB, ARK(0).
  - Totals for nr=10: 11 ARK, 10 ISB, 9 IMC.
- ark_n is zero-extended from round to N_W. ark_n=0 outside ARK states.
- Watchdog (TIMEOUT>0):
  - The counter resets on every state entry and increments each wait-state cycle.
  - When the counter reaches TIMEOUT with no owner done: drop all starts, set port_sel=0, set err=1, go to FIN.
  - A done arriving in the same cycle as the timeout wins; no error is flagged.
- ap_done/ap_idle/ap_ready/port_sel are registered from state; no combinational path from inputs to outputs.
- nr changes after accept are ignored.

Test Plan:
- nr=10, each done returned 3 cycles after start.
  - Counts: ark_start rises 11x, isb 10x, imc 9x.
  - ark_n sequence: 10,9,8,...,1,0.
  - ap_ready 1 pulse, ap_done 1 pulse, err=0.
- nr=1: ark_n sequence 1 then 0; 1 ISB; zero IMC starts; ap_done once.
- nr=0: only ARKL, with ark_n=0; ap_ready, then ap_done after ark_done.
- TIMEOUT=16, imc_done never asserted:
  - imc_start falls after 16 cycles in IMC; err=1, ap_done pulse, ap_idle=1.
  - Next ap_start clears err.
- Spurious isb_done/imc_done asserted during ARK0: ignored; state stays ARK0 until ark_done.
- ap_rst_n pulled low mid-ISB at round 5:
  - Immediately: all starts=0, port_sel=0, ap_idle=1, no ap_done.
  - A fresh start with nr=12 gives first ark_n=12.
